random_pool: RTL and testbench

- Parametrised successor to the game's table-based random source.
- Generates a batch of NUM_COUNT pseudo-random numbers, each NUM_LEN bits, from a Galois LFSR.
- Seeds itself from a free-running entropy counter at each start, so player timing perturbs the sequence.
- Optional per-batch upper bound via rejection sampling, with a capped-retry fallback. Feeds the obstacle/spawn logic with a one-cycle valid pulse.

---
 rtl/random_pool.sv | 182 ++++++++++++++++++
 tb/tb_random_pool.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/random_pool.sv
// -----------------------------------------------------------------------------
// random_pool
//   Produces a batch of NUM_COUNT pseudo-random numbers (NUM_LEN bits each)
//   from a Galois LFSR. The LFSR is reseeded at every batch start by mixing in
//   a free-running entropy counter, so the moment the player triggers a batch
//   perturbs the sequence. An optional exclusive upper bound is applied by
//   rejection sampling. After RETRY_MAX consecutive rejections the next
//   candidate is folded into range with a modulo instead.
//
// Ports
//   clock    in   rising-edge system clock
//   reset    in   asynchronous, active-low reset
//   start    in   batch request, sampled only while idle
//   limit    in   exclusive upper bound (0 = unbounded), captured at start
//   randoms  out  batch result, channel i at [i*NUM_LEN +: NUM_LEN]
//   valid    out  one-cycle pulse when randoms updates
//   busy     out  high while a batch is being generated
// -----------------------------------------------------------------------------
module random_pool #(
  parameter int                NUM_LEN   = 4,
  parameter int                NUM_COUNT = 3,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0] LFSR_INIT = 16'hACE1,
  parameter int                RETRY_MAX = 7
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_LEN-1:0]            limit,
  output logic [NUM_LEN*NUM_COUNT-1:0]  randoms,
  output logic                          valid,
  output logic                          busy
);

  localparam int OUT_W   = NUM_LEN * NUM_COUNT;
  localparam int IDX_W   = (NUM_COUNT > 1) ? $clog2(NUM_COUNT) : 1;
  localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_COUNT - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_MAX);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_GEN  = 1'b1;

  // One Galois LFSR step: shift right, fold the taps in when a 1 drops out.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] r;
    r = s >> 1;
    if (s[0]) begin
      r = r ^ TAPS;
    end else begin
      r = r;
    end
    return r;
  endfunction

  logic [0:0]         state_q,   state_d;
  logic [LFSR_W-1:0]  lfsr_q,    lfsr_d;
  logic [LFSR_W-1:0]  entropy_q;
  logic [IDX_W-1:0]   idx_q,     idx_d;
  logic [RETRY_W-1:0] retry_q,   retry_d;
  logic [OUT_W-1:0]   shadow_q,  shadow_d;
  logic [NUM_LEN-1:0] limit_q,   limit_d;
  logic [OUT_W-1:0]   randoms_q, randoms_d;
  logic               valid_q,   valid_d;
  logic               busy_q,    busy_d;

  logic [LFSR_W-1:0]  step_s;
  logic [LFSR_W-1:0]  mix_s;
  logic [NUM_LEN-1:0] cand_s;
  logic [NUM_LEN-1:0] value_s;
  logic               store_s;
  logic [OUT_W-1:0]   merged_s;

  // Next-state logic for the batch sequencer.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    shadow_d  = shadow_q;
    limit_d   = limit_q;
    randoms_d = randoms_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;

    step_s   = lfsr_step(lfsr_q);
    cand_s   = step_s[NUM_LEN-1:0];
    mix_s    = entropy_q ^ lfsr_q;
    value_s  = cand_s;
    store_s  = 1'b0;
    merged_s = shadow_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // An all-zero state would lock the LFSR, so substitute the init value.
          lfsr_d  = (mix_s == {LFSR_W{1'b0}}) ? LFSR_INIT : mix_s;
          limit_d = limit;
          idx_d   = {IDX_W{1'b0}};
          retry_d = {RETRY_W{1'b0}};
          busy_d  = 1'b1;
          state_d = ST_GEN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_GEN: begin
        // The LFSR advances on every generation edge, accepted or not.
        lfsr_d = step_s;
        // Retry exhausted: the candidate is folded into range untested. The
        // limit check keeps a zero bound out of the modulo.
        if ((limit_q != {NUM_LEN{1'b0}}) && (retry_q == RETRY_LIM)) begin
          store_s = 1'b1;
          value_s = cand_s % limit_q;
        end else if ((limit_q == {NUM_LEN{1'b0}}) || (cand_s < limit_q)) begin
          store_s = 1'b1;
          value_s = cand_s;
        end else begin
          retry_d = retry_q + 1'b1;
        end

        if (store_s) begin
          retry_d  = {RETRY_W{1'b0}};
          merged_s[idx_q * NUM_LEN +: NUM_LEN] = value_s;
          shadow_d = merged_s;
          if (idx_q == LAST_IDX) begin
            // Publish the whole batch at once, including the value just made.
            randoms_d = merged_s;
            valid_d   = 1'b1;
            busy_d    = 1'b0;
            idx_d     = {IDX_W{1'b0}};
            state_d   = ST_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          idx_d = idx_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; entropy runs free outside reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      lfsr_q    <= LFSR_INIT;
      entropy_q <= {LFSR_W{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      retry_q   <= {RETRY_W{1'b0}};
      shadow_q  <= {OUT_W{1'b0}};
      limit_q   <= {NUM_LEN{1'b0}};
      randoms_q <= {OUT_W{1'b0}};
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      entropy_q <= entropy_q + 1'b1;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      shadow_q  <= shadow_d;
      limit_q   <= limit_d;
      randoms_q <= randoms_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign randoms = randoms_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_random_pool.sv
// -----------------------------------------------------------------------------
// tb_random_pool
//   Scoreboarded bench for random_pool. The stimulus thread predicts each
//   batch (result and the cycle its valid pulse lands on) and queues it; a
//   monitor thread pops and compares whenever valid is seen. A second instance
//   with a short retry budget covers the modulo fallback.
// -----------------------------------------------------------------------------
module tb_random_pool;

  logic        clock;
  logic        reset;
  logic        start,   start2;
  logic [3:0]  limit,   limit2;
  logic [11:0] randoms, randoms2;
  logic        valid,   valid2;
  logic        busy,    busy2;

  typedef struct {
    logic [11:0] rnd;
    int          when;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  int          cyc = 0;
  logic [15:0] ent_m;
  logic [15:0] lfsr_m;
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          done    = 1'b0;

  random_pool dut (
    .clock(clock), .reset(reset), .start(start), .limit(limit),
    .randoms(randoms), .valid(valid), .busy(busy)
  );

  random_pool #(.RETRY_MAX(2)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .limit(limit2),
    .randoms(randoms2), .valid(valid2), .busy(busy2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Free cycle count, used to timestamp expected valid pulses.
  always @(posedge clock) cyc <= cyc + 1;

  // Entropy as seen by the design: counts every edge outside reset.
  always @(posedge clock or negedge reset) begin
    if (!reset) ent_m <= 16'h0000;
    else        ent_m <= ent_m + 16'd1;
  end

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Reference batch: seed mix, then draw candidates until every channel is
  // filled, counting the generation edges that takes.
  function automatic void model_batch(input logic [15:0] lf_in, input logic [15:0] ent,
                                      input logic [3:0] lim, input int rmax,
                                      output logic [11:0] rnd, output int n,
                                      output logic [15:0] lf_out);
    logic [15:0] s;
    logic [3:0]  cand;
    int          ch;
    int          tries;
    s = lf_in ^ ent;
    if (s == 16'h0000) s = 16'hACE1;
    rnd = 12'h000; n = 0; ch = 0; tries = 0;
    while (ch < 3) begin
      s = step(s);
      cand = s[3:0];
      n++;
      if (lim != 4'd0 && tries == rmax) begin
        rnd[ch*4 +: 4] = cand % lim; ch++; tries = 0;
      end else if (lim == 4'd0 || cand < lim) begin
        rnd[ch*4 +: 4] = cand; ch++; tries = 0;
      end else begin
        tries++;
      end
    end
    lf_out = s;
  endfunction

  // Issue one batch on dut at a falling edge while it is idle, then follow it
  // to the cycle its valid pulse is due.
  task automatic run_batch(input logic [3:0] lim, input bit hold, input bit poke,
                           input bit use_exp, input logic [11:0] exp_val);
    logic [11:0] r;
    logic [15:0] lf;
    int          n;
    int          c;
    int          pk;
    exp_t        e;
    c = cyc;
    model_batch(lfsr_m, ent_m, lim, 7, r, n, lf);
    lfsr_m = lf;
    e.rnd  = use_exp ? exp_val : r;
    e.when = c + 1 + n;
    q1.push_back(e);
    start = 1'b1;
    limit = lim;
    pk    = int'($urandom_range(n, 1));
    @(negedge clock);
    start = hold;
    limit = 4'($urandom);
    chk(busy === 1'b1, "busy_after_start", 32'(busy), 32'd1);
    while (cyc < c + 1 + n) begin
      start = (poke && cyc == c + pk) ? 1'b1 : hold;
      @(negedge clock);
    end
    start = hold;
    chk(busy === 1'b0, "busy_after_batch", 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; limit = 4'd0; start2 = 1'b0; limit2 = 4'd0;
    lfsr_m = 16'hACE1;
    fork
      // Monitor: compare each valid pulse against the head of its queue.
      begin
        exp_t e;
        while (!done) begin
          @(negedge clock);
          if (valid === 1'b1) begin
            if (q1.size() == 0) begin
              chk(1'b0, "unexpected_valid", 32'(randoms), 32'd0);
            end else begin
              e = q1.pop_front();
              chk(randoms === e.rnd, "randoms", 32'(randoms), 32'(e.rnd));
              chk(cyc == e.when, "valid_cycle", 32'(cyc), 32'(e.when));
            end
          end else if (q1.size() != 0 && cyc > q1[0].when) begin
            e = q1.pop_front();
            chk(1'b0, "missing_valid", 32'(cyc), 32'(e.when));
          end
          if (valid2 === 1'b1) begin
            if (q2.size() == 0) begin
              chk(1'b0, "unexpected_valid2", 32'(randoms2), 32'd0);
            end else begin
              e = q2.pop_front();
              chk(randoms2 === e.rnd, "randoms2", 32'(randoms2), 32'(e.rnd));
              chk(cyc == e.when, "valid2_cycle", 32'(cyc), 32'(e.when));
            end
          end else if (q2.size() != 0 && cyc > q2[0].when) begin
            e = q2.pop_front();
            chk(1'b0, "missing_valid2", 32'(cyc), 32'(e.when));
          end
        end
      end

      // Stimulus.
      begin
        logic [11:0] r;
        logic [15:0] lf;
        int          n;
        int          c;
        exp_t        e;

        // Reset asserted between clock edges takes effect at once.
        #1 reset = 1'b0;
        #1;
        chk(randoms === 12'h000, "reset_randoms", 32'(randoms), 32'h0);
        chk(valid === 1'b0, "reset_valid", 32'(valid), 32'h0);
        chk(busy === 1'b0, "reset_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clock);

        // Unbounded batch from the reset seed.
        reset = 1'b1;
        run_batch(4'd0, 1'b0, 1'b0, 1'b1, 12'hC80);

        // Mid-cycle reset clears a populated output.
        #2 reset = 1'b0;
        q1.delete(); lfsr_m = 16'hACE1;
        #1;
        chk(randoms === 12'h000, "midcycle_reset_randoms", 32'(randoms), 32'h0);
        chk(valid === 1'b0, "midcycle_reset_valid", 32'(valid), 32'h0);
        @(negedge clock);

        // Bounded batch with rejections.
        reset = 1'b1;
        run_batch(4'd5, 1'b0, 1'b0, 1'b1, 12'h430);

        // Reset after the first channel is stored: nothing partial escapes.
        c = cyc;
        start = 1'b1; limit = 4'd0;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        #2 reset = 1'b0;
        q1.delete(); lfsr_m = 16'hACE1;
        #1;
        chk(randoms === 12'h000, "abort_randoms", 32'(randoms), 32'h0);
        chk(busy === 1'b0, "abort_busy", 32'(busy), 32'h0);
        chk(valid === 1'b0, "abort_valid", 32'(valid), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        run_batch(4'd0, 1'b0, 1'b0, 1'b1, 12'hC80);

        // Fallback on the short-retry instance.
        reset = 1'b0;
        q1.delete(); q2.delete(); lfsr_m = 16'hACE1;
        @(negedge clock);
        reset = 1'b1;
        c = cyc;
        model_batch(16'hACE1, ent_m, 4'd5, 2, r, n, lf);
        e.rnd = 12'h340; e.when = c + 1 + n;
        q2.push_back(e);
        start2 = 1'b1; limit2 = 4'd5;
        @(negedge clock);
        start2 = 1'b0; limit2 = 4'd0;
        chk(busy2 === 1'b1, "busy2_after_start", 32'(busy2), 32'd1);
        while (cyc < c + 1 + n) @(negedge clock);
        chk(busy2 === 1'b0, "busy2_after_batch", 32'(busy2), 32'd0);

        // Randomised batches: bounds incl. 0/1/15, held start, mid-batch pokes.
        for (int b = 0; b < 40; b++) begin
          logic [3:0] lim;
          int gap;
          case ($urandom_range(3, 0))
            0:       lim = 4'd0;
            1:       lim = 4'd1;
            default: lim = 4'($urandom_range(15, 2));
          endcase
          gap = int'($urandom_range(3, 0));
          if (gap > 0) start = 1'b0;
          repeat (gap) @(negedge clock);
          run_batch(lim, ($urandom_range(2, 0) == 0), ($urandom_range(1, 0) == 1), 1'b0, 12'h000);
        end
        start = 1'b0;
        repeat (4) @(negedge clock);
        chk(q1.size() == 0, "q1_drained", 32'(q1.size()), 32'd0);
        chk(q2.size() == 0, "q2_drained", 32'(q2.size()), 32'd0);
        done = 1'b1;
      end
    join
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
